// File: rtl/add_pkg.sv
// Shared definitions for the shared-adder arbiter: operand layout, widths and FSM states.
// No logic; constants and types only.
// Imported by the arbiter top and by anything that builds or decodes operand words.
package add_pkg;

  localparam int OP_W    = 33;
  localparam int SUM_W   = 10;

  // Operand word field positions
  localparam int X_LSB   = 0;
  localparam int Y_LSB   = 8;
  localparam int Z_LSB   = 16;
  localparam int W_LSB   = 24;
  localparam int CIN_BIT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Increment an index with wrap at n
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/add_share_arb_rr_arb.sv
// Round-robin arbiter: first set request searching upward from ptr, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Scan N positions starting at ptr and take the first active request
  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Shares one registered adder among NUM_REQ requesters with round-robin grants, one op in flight.
// Latency: grant cycle T, response visible in cycle T+3; grants at least 4 cycles apart.
// Backpressure: response held until rsp_ready; no new grant until the response has been taken.
module add_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int OP_W    = add_pkg::OP_W,
  parameter int SUM_W   = add_pkg::SUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [OP_W-1:0]         add_ins,
  input  logic [SUM_W-1:0]        add_sm_r,
  input  logic                    add_zero_r,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SUM_W-1:0]        rsp_sum,
  output logic                    rsp_zero,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  import add_pkg::*;

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;

  rr_arb #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Grants are only offered while idle and out of reset; the operand register feeds the adder directly
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign add_ins   = op_q;
  assign busy      = (state != IDLE);

  // Transaction FSM: accept, let the adder register, capture result, hold response until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      id_q      <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_zero  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            op_q   <= req_data[int'(gnt_idx)*OP_W +: OP_W];
            id_q   <= gnt_idx;
            rr_ptr <= ID_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // Adder samples add_ins at the end of this cycle
          state <= CAPT;
        end
        CAPT: begin
          rsp_sum   <= add_sm_r;
          rsp_zero  <= add_zero_r;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb wired to a registered adder model.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Covers reset, single ops, zero/max sums, round-robin order, backpressure and mid-op reset.
module tb_add_share_arb;

  import add_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*OP_W-1:0] req_data = '0;
  logic [N-1:0]      req_ready;
  logic [OP_W-1:0]   add_ins;
  logic [SUM_W-1:0]  add_sm_r;
  logic              add_zero_r;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [SUM_W-1:0]  rsp_sum;
  logic              rsp_zero;
  logic [IW-1:0]     rsp_id;
  logic              busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Operand words {cin, w, z, y, x}
  localparam logic [OP_W-1:0] OP_T1   = 33'h1_3020_0C10; // 0x10+3+0x20+0x30+1 = 100
  localparam logic [OP_W-1:0] OP_ZERO = 33'h0_0000_0000; // 0
  localparam logic [OP_W-1:0] OP_MAX  = 33'h1_FFFF_0CFF; // 255+3+255+255+1 = 769
  localparam logic [OP_W-1:0] OP_A    = 33'h0_0302_0401; // 1+1+2+3 = 7
  localparam logic [OP_W-1:0] OP_B    = 33'h1_0000_0805; // 5+2+0+0+1 = 8
  localparam logic [OP_W-1:0] OP_C    = 33'h0_0001_00FF; // 255+0+1+0 = 256

  add_share_arb #(
    .NUM_REQ (N),
    .ID_W    (IW),
    .OP_W    (OP_W),
    .SUM_W   (SUM_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .add_ins    (add_ins),
    .add_sm_r   (add_sm_r),
    .add_zero_r (add_zero_r),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Adder: x + y[3:2] + z + w + cin, registered, with a zero flag
  logic [SUM_W-1:0] add_sum_nxt;
  always_comb begin
    add_sum_nxt = SUM_W'(add_ins[X_LSB +: 8]) + SUM_W'(add_ins[Y_LSB+2 +: 2]) +
                  SUM_W'(add_ins[Z_LSB +: 8]) + SUM_W'(add_ins[W_LSB +: 8]) +
                  SUM_W'(add_ins[CIN_BIT]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_sm_r   <= '0;
      add_zero_r <= 1'b0;
    end else begin
      add_sm_r   <= add_sum_nxt;
      add_zero_r <= (add_sum_nxt == '0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with rsp_ready held high; starts and ends 1ns after a rising edge in IDLE
  task automatic run_one(input string tag, input int idx, input logic [OP_W-1:0] op,
                         input logic [SUM_W-1:0] exp_sum, input logic exp_zero);
    int gcyc;
    bit got;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[idx*OP_W +: OP_W] = op;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    check({tag, "_gnt"}, req_ready, 64'(1) << idx);
    gcyc = cyc;
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check({tag, "_lat"}, cyc - gcyc, 3);
    check({tag, "_sum"}, rsp_sum, exp_sum);
    check({tag, "_zero"}, rsp_zero, exp_zero);
    check({tag, "_id"}, rsp_id, idx);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int w = 0; w < 20 && !done; w++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) done = 1'b1;
    end
    check({tag, "_idle"}, done, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gl[5];
    int ng;
    int last;
    bit seen;
    bit got;

    // Reset: requests present but nothing granted
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_in_reset", req_ready, 0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_add_ins", add_ins, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    tick();

    // Single requests: typical, zero, max
    run_one("t1", 0, OP_T1, 10'h064, 1'b0);
    run_one("zero", 2, OP_ZERO, 10'h000, 1'b1);
    run_one("max", 1, OP_MAX, 10'h301, 1'b0);

    // Reset in CAPT during a req3 transaction
    req_valid = '0;
    req_valid[3] = 1'b1;
    req_data[3*OP_W +: OP_W] = OP_T1;
    @(negedge clk);
    check("mid_gnt3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("mid_busy_issue", busy, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_add_ins", add_ins, 0);
    check("mid_rsp_sum", rsp_sum, 0);
    check("mid_rsp_id", rsp_id, 0);
    check("mid_req_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_no_rsp", seen, 0);
    tick();

    // All requesters continuously valid: pointer restarts at 0 after reset
    foreach (gl[k]) gl[k] = -1;
    ng = 0;
    last = 0;
    for (int i = 0; i < N; i++) req_data[i*OP_W +: OP_W] = OP_A;
    req_valid = 4'hF;
    for (int w = 0; w < 60 && ng < 5; w++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("rr_onehot", $countones(req_ready), 1);
        for (int i = 0; i < N; i++) if (req_ready[i]) gl[ng] = i;
        if (ng > 0) check("rr_spacing", cyc - last, 4);
        last = cyc;
        ng++;
      end
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) check("rr_order", gl[k], k % 4);
    wait_idle("rr");

    // Fresh req1 after the mid-op reset
    run_one("fresh", 1, OP_A, 10'd7, 1'b0);

    // Backpressure on req2's response while req0 waits
    rsp_ready = 1'b0;
    req_valid = '0;
    req_valid[2] = 1'b1;
    req_data[2*OP_W +: OP_W] = OP_B;
    @(negedge clk);
    check("bp_gnt2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("bp_rsp_seen", got, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      req_valid[0] = 1'b1;
      req_data[0*OP_W +: OP_W] = OP_C;
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_sum", rsp_sum, 10'd8);
      check("bp_hold_id", rsp_id, 2);
      check("bp_no_gnt", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_valid", rsp_valid, 1);
    check("bp_xfer_no_gnt", req_ready, 0);
    tick();
    @(negedge clk);
    check("bp_after_valid", rsp_valid, 0);
    check("bp_next_gnt", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("bp_r0_sum", rsp_sum, 10'h100);
    check("bp_r0_id", rsp_id, 0);
    tick();
    wait_idle("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
